// File: rtl/fetch_stage.sv
// Fetch-stage PC register and F/D pipeline register: one-edge latency from npc to f_pc and from f_pc to d_*.
// Backpressure: stall holds PC and F/D; req/eret redirect the PC and flush D to a bubble.
module fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [31:0] IM_BASE    = 32'h0000_3000,
   parameter logic [31:0] IM_TOP     = 32'h0000_6FFC
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] npc,
   input  logic        stall,
   input  logic        is_branch_d,
   input  logic        eret_d,
   input  logic        req,
   input  logic [31:0] epc,
   input  logic [31:0] i_instr,
   output logic [31:0] f_pc,
   output logic [31:0] d_pc,
   output logic [31:0] d_instr,
   output logic [4:0]  d_exccode,
   output logic        d_bd,
   output logic        d_valid
);

   logic        f_adel;
   logic [31:0] f_instr;
   logic [4:0]  f_exccode;

   // Bad fetches still advance; the AdEL tag rides with a nop-like zero word.
   always_comb begin
      f_adel    = (f_pc[1:0] != 2'b00) || (f_pc < IM_BASE) || (f_pc > IM_TOP);
      f_instr   = f_adel ? 32'h0 : i_instr;
      f_exccode = f_adel ? 5'd4 : 5'd0;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         f_pc      <= RESET_PC;
         d_pc      <= RESET_PC;
         d_instr   <= 32'h0;
         d_exccode <= 5'd0;
         d_bd      <= 1'b0;
         d_valid   <= 1'b0;
      end else if (req) begin
         f_pc      <= HANDLER_PC;
         d_pc      <= HANDLER_PC;
         d_instr   <= 32'h0;
         d_exccode <= 5'd0;
         d_bd      <= 1'b0;
         d_valid   <= 1'b0;
      end else if (stall) begin
         f_pc      <= f_pc;
         d_pc      <= d_pc;
         d_instr   <= d_instr;
         d_exccode <= d_exccode;
         d_bd      <= d_bd;
         d_valid   <= d_valid;
      end else if (eret_d) begin
         // The instruction behind eret is squashed, never executed.
         f_pc      <= epc;
         d_pc      <= epc;
         d_instr   <= 32'h0;
         d_exccode <= 5'd0;
         d_bd      <= 1'b0;
         d_valid   <= 1'b0;
      end else begin
         f_pc      <= npc;
         d_pc      <= f_pc;
         d_instr   <= f_instr;
         d_exccode <= f_exccode;
         d_bd      <= is_branch_d;
         d_valid   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: hand-computed PC and F/D values after each edge.
module tb_fetch_stage;

   logic        clk;
   logic        reset;
   logic [31:0] npc;
   logic        stall;
   logic        is_branch_d;
   logic        eret_d;
   logic        req;
   logic [31:0] epc;
   logic [31:0] i_instr;
   logic [31:0] f_pc;
   logic [31:0] d_pc;
   logic [31:0] d_instr;
   logic [4:0]  d_exccode;
   logic        d_bd;
   logic        d_valid;

   int total = 0;
   int bad   = 0;

   fetch_stage dut (
      .clk         (clk),
      .reset       (reset),
      .npc         (npc),
      .stall       (stall),
      .is_branch_d (is_branch_d),
      .eret_d      (eret_d),
      .req         (req),
      .epc         (epc),
      .i_instr     (i_instr),
      .f_pc        (f_pc),
      .d_pc        (d_pc),
      .d_instr     (d_instr),
      .d_exccode   (d_exccode),
      .d_bd        (d_bd),
      .d_valid     (d_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_d(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                        input logic [4:0] exc, input logic bd, input logic vld);
      chk({tag, ".d_pc"}, d_pc, pc);
      chk({tag, ".d_instr"}, d_instr, instr);
      chk({tag, ".d_exccode"}, {27'b0, d_exccode}, {27'b0, exc});
      chk({tag, ".d_bd"}, {31'b0, d_bd}, {31'b0, bd});
      chk({tag, ".d_valid"}, {31'b0, d_valid}, {31'b0, vld});
   endtask

   initial begin
      reset = 1'b0; npc = 32'h0; stall = 1'b0; is_branch_d = 1'b0;
      eret_d = 1'b0; req = 1'b0; epc = 32'h0; i_instr = 32'h3C01_1234;
      step(); step();
      chk("rst.f_pc", f_pc, 32'h3000);
      chk_d("rst", 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0);

      // Release reset and advance sequentially.
      reset = 1'b1; npc = 32'h3004;
      step();
      chk("adv1.f_pc", f_pc, 32'h3004);
      chk_d("adv1", 32'h3000, 32'h3C01_1234, 5'd0, 1'b0, 1'b1);
      npc = 32'h3008;
      step();
      chk("adv2.f_pc", f_pc, 32'h3008);
      chk_d("adv2", 32'h3004, 32'h3C01_1234, 5'd0, 1'b0, 1'b1);

      // Stall for three edges; eret and changing inputs must be ignored.
      stall = 1'b1; npc = 32'h3100; i_instr = 32'hDEAD_BEEF; is_branch_d = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) eret_d = 1'b1; else eret_d = 1'b0;
         epc = 32'h5000;
         step();
         chk("stall.f_pc", f_pc, 32'h3008);
         chk_d("stall", 32'h3004, 32'h3C01_1234, 5'd0, 1'b0, 1'b1);
      end
      stall = 1'b0; eret_d = 1'b0; is_branch_d = 1'b0;
      npc = 32'h300C; i_instr = 32'h2000_0001;
      step();
      chk("unstall.f_pc", f_pc, 32'h300C);
      chk_d("unstall", 32'h3008, 32'h2000_0001, 5'd0, 1'b0, 1'b1);

      // Delay-slot flag captured on advance.
      is_branch_d = 1'b1; npc = 32'h3010; i_instr = 32'h1000_0003;
      step();
      chk("bd.f_pc", f_pc, 32'h3010);
      chk_d("bd", 32'h300C, 32'h1000_0003, 5'd0, 1'b1, 1'b1);

      // req beats stall and forces d_bd low.
      req = 1'b1; stall = 1'b1;
      step();
      chk("req.f_pc", f_pc, 32'h4180);
      chk_d("req", 32'h4180, 32'h0, 5'd0, 1'b0, 1'b0);
      req = 1'b0; stall = 1'b0; is_branch_d = 1'b1; npc = 32'h4184; i_instr = 32'h0000_0020;
      step();
      chk("hnd.f_pc", f_pc, 32'h4184);
      chk_d("hnd", 32'h4180, 32'h0000_0020, 5'd0, 1'b1, 1'b1);
      is_branch_d = 1'b0; npc = 32'h4188;
      step();
      chk_d("bdclr", 32'h4184, 32'h0000_0020, 5'd0, 1'b0, 1'b1);

      // eret held off by stall, then redirects.
      eret_d = 1'b1; stall = 1'b1; epc = 32'h3020; npc = 32'h9990;
      step();
      chk("eretst.f_pc", f_pc, 32'h4188);
      chk_d("eretst", 32'h4184, 32'h0000_0020, 5'd0, 1'b0, 1'b1);
      stall = 1'b0;
      step();
      chk("eret.f_pc", f_pc, 32'h3020);
      chk_d("eret", 32'h3020, 32'h0, 5'd0, 1'b0, 1'b0);
      eret_d = 1'b0;

      // Address-error fetches advance with AdEL tag and a zero word.
      i_instr = 32'h2408_0005; npc = 32'h3002;
      step();
      chk_d("ok3020", 32'h3020, 32'h2408_0005, 5'd0, 1'b0, 1'b1);
      npc = 32'h2FFC;
      step();
      chk("mis.f_pc", f_pc, 32'h2FFC);
      chk_d("mis", 32'h3002, 32'h0, 5'd4, 1'b0, 1'b1);
      npc = 32'h7000;
      step();
      chk_d("low", 32'h2FFC, 32'h0, 5'd4, 1'b0, 1'b1);
      npc = 32'h6FFC;
      step();
      chk_d("high", 32'h7000, 32'h0, 5'd4, 1'b0, 1'b1);
      npc = 32'h3000;
      step();
      chk_d("top", 32'h6FFC, 32'h2408_0005, 5'd0, 1'b0, 1'b1);

      // Reset asserted while stalled wins on the same edge.
      stall = 1'b1; reset = 1'b0;
      step();
      chk("rst2.f_pc", f_pc, 32'h3000);
      chk_d("rst2", 32'h3000, 32'h0, 5'd0, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
